// File: rtl/mul_sched_pkg.sv
// Shared constants and tag type for the multiplier request scheduler.
// Default parameters here must match the shared boothmul instance.
package mul_sched_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NREQ    = 2;
  localparam int DEF_LATENCY = 10;
  localparam int DEF_DEPTH   = 16;

  // Tag ids are sized for the largest supported requester count (8).
  localparam int MAX_IDW = 3;

  typedef struct packed {
    logic               valid;
    logic [MAX_IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/mul_sched_fifo.sv
// Synchronous response FIFO with asynchronous reset of its pointers and count.
// The head entry reads as zero while empty, so stale contents never leak out.
module mul_sched_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push   ? wrap_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? wrap_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // When full, a same-edge pop frees the slot the push lands in.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !do_pop));

endmodule

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among NREQ requesters,
// returning products in accept order through a credit-guarded response FIFO.
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREQ    = DEF_NREQ,
  parameter int LATENCY = DEF_LATENCY,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_w,
  input  logic [NREQ*WIDTH-1:0]     req_x,
  output logic [WIDTH-1:0]          mul_w,
  output logic [WIDTH-1:0]          mul_x,
  input  logic [2*WIDTH-1:0]        mul_res,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [2*WIDTH-1:0]        rsp_data,
  output logic                      busy
);

  localparam int IDW  = $clog2(NREQ);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int EW   = IDW + 2*WIDTH;

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0] outstanding_q, outstanding_d;
  tag_t            tag_q [LATENCY];
  tag_t            tag_d [LATENCY];

  logic            can_accept;
  logic            grant_valid;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  arb_idx;
  logic            push, pop, fifo_empty;
  logic [EW-1:0]   push_data, pop_data;

  // Credits cover both in-flight tags and queued responses, so the FIFO can
  // never overflow; a pop in the same cycle deliberately does not bypass.
  assign can_accept = !rst && (outstanding_q < CNTW'(DEPTH));

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    arb_idx     = rr_ptr_q;
    if (can_accept) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!grant_valid && req_valid[arb_idx]) begin
          grant_valid = 1'b1;
          grant_id    = arb_idx;
        end
        arb_idx = (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    mul_w     = '0;
    mul_x     = '0;
    if (grant_valid) begin
      req_ready[grant_id] = 1'b1;
      mul_w = req_w[grant_id*WIDTH +: WIDTH];
      mul_x = req_x[grant_id*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    tag_d[0] = '{valid: grant_valid, id: MAX_IDW'(grant_id)};
    for (int k = 1; k < LATENCY; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      rr_ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end
    outstanding_d = outstanding_q;
    if (grant_valid && !pop) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (pop && !grant_valid) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      outstanding_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      outstanding_q <= outstanding_d;
      tag_q         <= tag_d;
    end
  end

  // The last tag stage lines up with the product appearing on mul_res.
  assign push      = tag_q[LATENCY-1].valid;
  assign push_data = {tag_q[LATENCY-1].id[IDW-1:0], mul_res};

  mul_sched_fifo #(
    .DEPTH (DEPTH),
    .DW    (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .empty     (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_id    = pop_data[EW-1 -: IDW];
  assign rsp_data  = pop_data[2*WIDTH-1:0];
  assign busy      = (outstanding_q != '0);

endmodule

// File: tb/tb_mul_sched.sv
// Scoreboard bench for mul_sched with a behavioural pipelined multiplier in
// place of boothmul and a round-robin/credit reference model.
module tb_mul_sched;
  import mul_sched_pkg::*;

  localparam int WIDTH = DEF_WIDTH;
  localparam int NREQ  = DEF_NREQ;
  localparam int LAT   = DEF_LATENCY;
  localparam int DEPTH = DEF_DEPTH;
  localparam int IDW   = $clog2(NREQ);

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_w;
  logic [NREQ*WIDTH-1:0] req_x;
  logic [WIDTH-1:0]      mul_w;
  logic [WIDTH-1:0]      mul_x;
  logic [2*WIDTH-1:0]    mul_res;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_data;
  logic                  busy;

  typedef struct {
    int id;
    int data;
  } exp_t;

  exp_t exp_list[$];
  int   cmp_cnt    = 0;
  int   fail_cnt   = 0;
  int   pop_idx    = 0;
  int   rr_m       = 0;
  int   pop_total  = 0;
  int   valid_seen = 0;

  logic [2*WIDTH-1:0] mpipe [LAT];

  mul_sched #(
    .WIDTH   (WIDTH),
    .NREQ    (NREQ),
    .LATENCY (LAT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_w     (req_w),
    .req_x     (req_x),
    .mul_w     (mul_w),
    .mul_x     (mul_x),
    .mul_res   (mul_res),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for boothmul: product appears on mul_res LAT edges after the operands.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) mpipe[i] <= '0;
    end else begin
      mpipe[0] <= mul_w * mul_x;
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_res = mpipe[LAT-1];

  task automatic check_output(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: predicts the grant for the coming edge from pending requests,
  // the round-robin pointer and the credits not yet returned by a response pop.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        rr_m = 0;
      end else begin
        int outst, g, ew, ex, idx;
        outst = exp_list.size() - pop_idx;
        g = -1;
        if (outst < DEPTH) begin
          for (int k = 0; k < NREQ; k++) begin
            idx = (rr_m + k) % NREQ;
            if (g < 0 && ((int'(req_valid) >> idx) & 1) == 1) g = idx;
          end
        end
        ew = 0;
        ex = 0;
        if (g >= 0) begin
          ew = (int'(req_w) >> (g*WIDTH)) & ((1 << WIDTH) - 1);
          ex = (int'(req_x) >> (g*WIDTH)) & ((1 << WIDTH) - 1);
        end
        check_output("req_ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
        check_output("busy", int'(busy), (outst != 0) ? 1 : 0);
        check_output("mul_w", int'(mul_w), ew);
        check_output("mul_x", int'(mul_x), ex);
        if (g >= 0) begin
          exp_list.push_back('{id: g, data: (ew * ex) % (1 << (2*WIDTH))});
          rr_m = (g + 1) % NREQ;
        end
      end
    end
  end

  // Monitor: every response handshake must match the oldest unreturned accept.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        pop_idx = exp_list.size();
      end else begin
        if (rsp_valid) valid_seen++;
        if (rsp_valid && rsp_ready) begin
          if (pop_idx >= exp_list.size()) begin
            cmp_cnt++;
            fail_cnt++;
            $display("[TB] FAIL rsp_unexpected: got id=%0d data=0x%0h, expected no response at %0t",
                     rsp_id, rsp_data, $time);
          end else begin
            check_output("rsp_id", int'(rsp_id), exp_list[pop_idx].id);
            check_output("rsp_data", int'(rsp_data), exp_list[pop_idx].data);
            pop_idx++;
          end
          pop_total++;
        end
      end
    end
  end

  // One cycle: drive at posedge+1, sample accept before the edge, return at posedge+1.
  task automatic apply_stimulus(input logic [NREQ-1:0] v, input logic rr, input bit rand_ops,
                                output int acc);
    req_valid = v;
    rsp_ready = rr;
    if (rand_ops) begin
      req_w = (NREQ*WIDTH)'($urandom);
      req_x = (NREQ*WIDTH)'($urandom);
    end
    #2;
    acc = ((req_valid & req_ready) != '0) ? 1 : 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, edges, n, v0;
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b0;
    req_w     = (NREQ*WIDTH)'($urandom);
    req_x     = (NREQ*WIDTH)'($urandom);
    repeat (3) @(posedge clk);
    #3;
    check_output("rst_req_ready", int'(req_ready), 0);
    check_output("rst_rsp_valid", int'(rsp_valid), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_mul_w", int'(mul_w), 0);
    check_output("rst_rsp_data", int'(rsp_data), 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;

    // Single request from requester 0: 3 * 5.
    req_w = '0;
    req_x = '0;
    req_w[0 +: WIDTH] = WIDTH'(3);
    req_x[0 +: WIDTH] = WIDTH'(5);
    apply_stimulus(NREQ'(1), 1'b1, 1'b0, acc);
    check_output("single_accept", acc, 1);
    edges = 1;
    while (!rsp_valid && edges < 4*LAT) begin
      apply_stimulus('0, 1'b1, 1'b0, acc);
      edges++;
    end
    check_output("single_latency", edges, LAT + 1);
    check_output("single_id", int'(rsp_id), 0);
    check_output("single_data", int'(rsp_data), 15);
    repeat (3) apply_stimulus('0, 1'b1, 1'b0, acc);

    // Maximum operands from requester 1.
    req_w[WIDTH +: WIDTH] = '1;
    req_x[WIDTH +: WIDTH] = '1;
    apply_stimulus(NREQ'(2), 1'b1, 1'b0, acc);
    edges = 1;
    while (!rsp_valid && edges < 4*LAT) begin
      apply_stimulus('0, 1'b1, 1'b0, acc);
      edges++;
    end
    check_output("max_latency", edges, LAT + 1);
    check_output("max_id", int'(rsp_id), 1);
    check_output("max_data", int'(rsp_data), 'hFE01);
    repeat (3) apply_stimulus('0, 1'b1, 1'b0, acc);

    // Both requesters always valid: alternating grants, one response per cycle.
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) n = pop_total;
      apply_stimulus('1, 1'b1, 1'b1, acc);
    end
    check_output("steady_throughput", pop_total - n, 20);
    repeat (20) apply_stimulus('0, 1'b1, 1'b0, acc);
    check_output("alt_drained_busy", int'(busy), 0);

    // Backpressure: credits run out at DEPTH, one pop allows exactly one more.
    n = 0;
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(NREQ'(1), 1'b0, 1'b1, acc);
      n += acc;
    end
    check_output("bp_accepts", n, DEPTH);
    check_output("bp_ready_low", acc, 0);
    apply_stimulus(NREQ'(1), 1'b1, 1'b1, acc);
    check_output("bp_no_bypass", acc, 0);
    apply_stimulus(NREQ'(1), 1'b0, 1'b1, acc);
    check_output("bp_accept_after_pop", acc, 1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(NREQ'(1), 1'b0, 1'b1, acc);
      n += acc;
    end
    check_output("bp_single_extra", n, 0);
    repeat (DEPTH + LAT + 10) apply_stimulus('0, 1'b1, 1'b0, acc);
    check_output("bp_drained_busy", int'(busy), 0);

    // Random traffic, alternating light and heavy backpressure phases.
    for (int i = 0; i < 400; i++) begin
      logic rr;
      if (((i / 50) % 2) == 1) rr = (($urandom % 4) == 0);
      else                     rr = (($urandom % 4) != 0);
      apply_stimulus(NREQ'($urandom), rr, 1'b1, acc);
    end
    repeat (DEPTH + LAT + 10) apply_stimulus('0, 1'b1, 1'b0, acc);
    check_output("rand_drained", pop_idx, exp_list.size());

    // Reset with five queued and five in-flight requests.
    repeat (5) apply_stimulus(NREQ'(1), 1'b0, 1'b1, acc);
    repeat (LAT + 2) apply_stimulus('0, 1'b0, 1'b0, acc);
    repeat (5) apply_stimulus(NREQ'(2), 1'b0, 1'b1, acc);
    #1;
    check_output("pre_reset_rsp_valid", int'(rsp_valid), 1);
    check_output("pre_reset_busy", int'(busy), 1);
    req_valid = '1;
    rst = 1'b1;
    #1;
    check_output("mid_rst_rsp_valid", int'(rsp_valid), 0);
    check_output("mid_rst_busy", int'(busy), 0);
    check_output("mid_rst_req_ready", int'(req_ready), 0);
    check_output("mid_rst_mul_w", int'(mul_w), 0);
    check_output("mid_rst_mul_x", int'(mul_x), 0);
    check_output("mid_rst_rsp_id", int'(rsp_id), 0);
    check_output("mid_rst_rsp_data", int'(rsp_data), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    v0 = valid_seen;
    repeat (2*LAT) apply_stimulus('0, 1'b1, 1'b0, acc);
    check_output("no_stale_rsp", valid_seen - v0, 0);

    // Recovery after reset: requester 0 must win again from a cleared pointer.
    req_w[0 +: WIDTH] = WIDTH'(7);
    req_x[0 +: WIDTH] = WIDTH'(9);
    apply_stimulus('1, 1'b1, 1'b0, acc);
    check_output("post_rst_accept", acc, 1);
    repeat (LAT + 5) apply_stimulus('0, 1'b1, 1'b0, acc);
    check_output("final_drained", pop_idx, exp_list.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
